// File: rtl/mult.sv
// mult: 32x32 -> 64 sequential shift-add multiplier, 32 iterations per operation.
// Define MULT_SIGNED_EN to compile in signed (MULT) mode; otherwise Signed is ignored.
module mult (
    input  logic        clk,
    input  logic        reset,
    input  logic        validIn,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        Signed,
    output logic        validOut,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      r_state;
    logic [63:0] r_mcand;
    logic [63:0] r_acc;
    logic [31:0] r_mplier;
    logic [4:0]  r_cnt;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [63:0] w_sum;
    logic [63:0] w_prod;
    assign w_sum = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
`ifdef MULT_SIGNED_EN
    logic r_neg;
    // Magnitudes are multiplied unsigned; 0x80000000 negates to itself, which is 2^31 unsigned.
    assign w_mag_a = (Signed && SrcA[31]) ? -SrcA : SrcA;
    assign w_mag_b = (Signed && SrcB[31]) ? -SrcB : SrcB;
    assign w_prod  = r_neg ? -w_sum : w_sum;
    always_ff @(posedge clk) begin
        if (reset)
            r_neg <= 1'b0;
        else if (validIn && r_state != BUSY)
            r_neg <= Signed && (SrcA[31] ^ SrcB[31]);
    end
`else
    logic w_unused_signed;
    assign w_unused_signed = Signed;
    assign w_mag_a = SrcA;
    assign w_mag_b = SrcB;
    assign w_prod  = w_sum;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            validOut <= 1'b0;
            Hi       <= 32'd0;
            Lo       <= 32'd0;
            r_acc    <= 64'd0;
            r_cnt    <= 5'd0;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
        end else begin
            validOut <= 1'b0;
            case (r_state)
                BUSY: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        Hi       <= w_prod[63:32];
                        Lo       <= w_prod[31:0];
                        validOut <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                default: begin
                    if (validIn) begin
                        r_mcand  <= {32'd0, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_acc    <= 64'd0;
                        r_cnt    <= 5'd0;
                        r_state  <= BUSY;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult.sv
// tb_mult: directed-vector bench for mult; signed vectors run when MULT_SIGNED_EN is defined.
module tb_mult;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        validIn = 1'b0;
    logic        Signed = 1'b0;
    logic [31:0] SrcA = 32'd0;
    logic [31:0] SrcB = 32'd0;
    logic        validOut;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic [63:0] last;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mult dut (
        .clk(clk), .reset(reset), .validIn(validIn), .SrcA(SrcA), .SrcB(SrcB),
        .Signed(Signed), .validOut(validOut), .Hi(Hi), .Lo(Lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        SrcA = a; SrcB = b; Signed = s; validIn = 1'b1;
        @(negedge clk);
        validIn = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!validOut && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [63:0] exp);
        int n;
        start(a, b, s);
        wait_done(n);
        check({tag, "_lat"}, 64'(n), 64'd32);
        check(tag, {Hi, Lo}, exp);
        last = exp;
        @(negedge clk);
        check({tag, "_pulse"}, {63'd0, validOut}, 64'd0);
    endtask

    initial begin
        int n;
        int seen;
        repeat (3) @(negedge clk);
        check("rst_vout", {63'd0, validOut}, 64'd0);
        check("rst_hilo", {Hi, Lo}, 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_vout", {63'd0, validOut}, 64'd0);

        op("u54x101", 32'd54, 32'd101, 1'b0, 64'd5454);
        op("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
        op("zero", 32'd0, 32'h12345678, 1'b0, 64'd0);
`ifdef MULT_SIGNED_EN
        op("s_neg", 32'hFFFFFFCA, 32'd101, 1'b1, 64'hFFFFFFFF_FFFFEAB2);
        op("s_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1);
        op("s_minmin", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
        op("s_min1", 32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF_80000000);
        op("u_in_s", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
`else
        op("sig_ignored", 32'hFFFFFFCA, 32'd101, 1'b1, 64'h00000064_FFFFEAB2);
`endif

        // validIn pulsed mid-run with new operands must not disturb the 3x5 operation
        start(32'd3, 32'd5, 1'b0);
        n = 0;
        while (!validOut && n < 40) begin
            if (n == 10) begin SrcA = 32'd7; SrcB = 32'd9; validIn = 1'b1; end
            if (n == 11) validIn = 1'b0;
            if (n == 20) check("busy_hold", {Hi, Lo}, last);
            @(negedge clk);
            n++;
        end
        check("busy_lat", 64'(n), 64'd32);
        check("busy_res", {Hi, Lo}, 64'd15);
        @(negedge clk);

        start(32'd54, 32'd101, 1'b0);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_hilo", {Hi, Lo}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (validOut) seen++;
        end
        check("midrst_nopulse", 64'(seen), 64'd0);
        check("midrst_hold", {Hi, Lo}, 64'd0);
        op("after_rst", 32'd2, 32'd3, 1'b0, 64'd6);

        start(32'd10, 32'd10, 1'b0);
        wait_done(n);
        check("b2b1_lat", 64'(n), 64'd32);
        check("b2b1_res", {Hi, Lo}, 64'd100);
        SrcA = 32'd4; SrcB = 32'd4; Signed = 1'b0; validIn = 1'b1;
        @(negedge clk);
        validIn = 1'b0;
        check("b2b_vout_low", {63'd0, validOut}, 64'd0);
        wait_done(n);
        check("b2b2_lat", 64'(n), 64'd32);
        check("b2b2_res", {Hi, Lo}, 64'd16);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
